// File: rtl/hub_egress_rr_arbiter.sv
// Hub egress arbiter: sc has strict priority, grid FIFOs round-robin, 2-entry output buffer.
// Optional perf counters enabled by defining HUB_ARB_PERF_COUNTERS_EN.
module hub_egress_rr_arbiter #(
    parameter int FIFO_COUNT     = 8,
    parameter int HUB_FIFO_WIDTH = 64,
    parameter int FIFO_IDWIDTH   = 4,
    parameter int DATA_WIDTH     = HUB_FIFO_WIDTH - FIFO_IDWIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH*FIFO_COUNT-1:0] in_data_vector,
    input  logic [FIFO_COUNT-1:0]            in_valid_vector,
    output logic [FIFO_COUNT-1:0]            in_ready_vector,
    input  logic [DATA_WIDTH-1:0]            sc_in_data,
    input  logic                             sc_in_valid,
    output logic                             sc_in_ready,
    output logic [HUB_FIFO_WIDTH-1:0]        out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
`ifdef HUB_ARB_PERF_COUNTERS_EN
    output logic [31:0]                      perf_words_out,
    output logic [31:0]                      perf_stall_cycles,
`endif
    output logic                             has_flying_messages
);

    localparam int PTR_W = (FIFO_COUNT > 1) ? $clog2(FIFO_COUNT) : 1;

    logic [PTR_W-1:0]          r_rr_ptr;
    logic [1:0]                r_count;
    logic [HUB_FIFO_WIDTH-1:0] r_q0;
    logic [HUB_FIFO_WIDTH-1:0] r_q1;

    logic                      w_can_accept;
    logic                      w_grid_hit;
    logic [PTR_W-1:0]          w_grant_idx;
    logic [PTR_W-1:0]          w_idx;
    logic                      w_sc_win;
    logic                      w_grid_acc;
    logic                      w_push;
    logic                      w_pop;
    logic [HUB_FIFO_WIDTH-1:0] w_push_data;

    assign w_can_accept = (r_count != 2'd2);

    // First valid port at or after the round-robin pointer
    always_comb begin
        w_grid_hit  = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        for (int k = 0; k < FIFO_COUNT; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % FIFO_COUNT);
            if (!w_grid_hit && in_valid_vector[w_idx]) begin
                w_grid_hit  = 1'b1;
                w_grant_idx = w_idx;
            end
        end
    end

    assign w_sc_win    = !reset && sc_in_valid && w_can_accept;
    assign sc_in_ready = w_sc_win;
    assign w_grid_acc  = !reset && !w_sc_win && w_grid_hit && w_can_accept;

    always_comb begin
        in_ready_vector = '0;
        if (!reset && !w_sc_win && w_grid_hit)
            in_ready_vector[w_grant_idx] = w_can_accept;
    end

    always_comb begin
        if (w_sc_win)
            w_push_data = {FIFO_IDWIDTH'(FIFO_COUNT), sc_in_data};
        else
            w_push_data = {FIFO_IDWIDTH'(w_grant_idx),
                           in_data_vector[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH]};
    end

    assign w_push              = w_sc_win || w_grid_acc;
    assign out_valid           = (r_count != 2'd0);
    assign out_data            = r_q0;
    assign w_pop               = out_valid && out_ready;
    assign has_flying_messages = (|in_valid_vector) || sc_in_valid || out_valid;

    // r_q0 is always the head; a pop shifts r_q1 forward or takes the new word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_rr_ptr <= '0;
            r_q0     <= '0;
            r_q1     <= '0;
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_grid_acc)
                r_rr_ptr <= (w_grant_idx == PTR_W'(FIFO_COUNT - 1)) ? '0 : w_grant_idx + 1'b1;
            if (w_pop) begin
                if (r_count == 2'd2)
                    r_q0 <= r_q1;
                else if (w_push)
                    r_q0 <= w_push_data;
            end else if (w_push) begin
                if (r_count == 2'd0)
                    r_q0 <= w_push_data;
                else
                    r_q1 <= w_push_data;
            end
        end
    end

`ifdef HUB_ARB_PERF_COUNTERS_EN
    logic [31:0] r_perf_words;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_words <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_pop && r_perf_words != 32'hFFFF_FFFF)
                r_perf_words <= r_perf_words + 32'd1;
            if (out_valid && !out_ready && r_perf_stall != 32'hFFFF_FFFF)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_words_out    = r_perf_words;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_hub_egress_rr_arbiter.sv
// Randomized + directed bench for hub_egress_rr_arbiter with a queue-based reference model.
// Perf counter checks are active when HUB_ARB_PERF_COUNTERS_EN is defined.
module tb_hub_egress_rr_arbiter;
    localparam int N   = 8;
    localparam int W   = 64;
    localparam int IDW = 4;
    localparam int DW  = W - IDW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW*N-1:0] in_data_vector;
    logic [N-1:0]  in_valid_vector;
    logic [N-1:0]  in_ready_vector;
    logic [DW-1:0] sc_in_data;
    logic          sc_in_valid;
    logic          sc_in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          has_flying_messages;
`ifdef HUB_ARB_PERF_COUNTERS_EN
    logic [31:0]   perf_words_out;
    logic [31:0]   perf_stall_cycles;
`endif

    hub_egress_rr_arbiter #(
        .FIFO_COUNT(N), .HUB_FIFO_WIDTH(W), .FIFO_IDWIDTH(IDW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data_vector(in_data_vector),
        .in_valid_vector(in_valid_vector),
        .in_ready_vector(in_ready_vector),
        .sc_in_data(sc_in_data),
        .sc_in_valid(sc_in_valid),
        .sc_in_ready(sc_in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef HUB_ARB_PERF_COUNTERS_EN
        .perf_words_out(perf_words_out),
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .has_flying_messages(has_flying_messages)
    );

    always #5 clk = ~clk;

    // producer state
    bit            g_val[N];
    logic [DW-1:0] g_dat[N];
    bit            g_stream[N];
    bit            sc_val;
    logic [DW-1:0] sc_dat;
    bit            sc_stream;

    // reference model
    logic [W-1:0]   mq[$];
    int             m_rr;
    bit             known;
    int             m_pops;
    int             m_acc;
    logic [IDW-1:0] pop_tags[$];
    logic [31:0]    m_pw;
    logic [31:0]    m_ps;

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid_vector[i]           = g_val[i];
            in_data_vector[i*DW +: DW]   = g_dat[i];
        end
        sc_in_valid = sc_val;
        sc_in_data  = sc_dat;
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            g_val[i]    = 1'b0;
            g_stream[i] = 1'b0;
            g_dat[i]    = '0;
        end
        sc_val    = 1'b0;
        sc_stream = 1'b0;
        sc_dat    = '0;
    endtask

    // called at a negedge with inputs prepared; returns at the next negedge
    task automatic cycle();
        logic [N-1:0] e_ir;
        bit           e_sc;
        bit           can;
        bit           pop;
        int           g;
        drive();
        #1;
        e_ir = '0;
        e_sc = 1'b0;
        g    = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && g_val[(m_rr + k) % N]) g = (m_rr + k) % N;
        can = (mq.size() < 2);
        if (!reset) begin
            if (sc_val && can) e_sc = 1'b1;
            else if (g >= 0) e_ir[g] = can;
        end
        chk("in_ready", 64'(in_ready_vector), 64'(e_ir));
        chk("sc_ready", 64'(sc_in_ready), 64'(e_sc));
        if (known) begin
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) chk("out_data", out_data, mq[0]);
            chk("flying", 64'(has_flying_messages),
                64'((|in_valid_vector) || sc_val || mq.size() != 0));
`ifdef HUB_ARB_PERF_COUNTERS_EN
            chk("perf_words", 64'(perf_words_out), 64'(m_pw));
            chk("perf_stall", 64'(perf_stall_cycles), 64'(m_ps));
`endif
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_rr  = 0;
            known = 1'b1;
            m_pw  = '0;
            m_ps  = '0;
        end else begin
            pop = (mq.size() != 0) && out_ready;
            if (mq.size() != 0 && !out_ready && m_ps != 32'hFFFF_FFFF) m_ps++;
            if (pop) begin
                pop_tags.push_back(mq[0][W-1 -: IDW]);
                void'(mq.pop_front());
                m_pops++;
                if (m_pw != 32'hFFFF_FFFF) m_pw++;
            end
            if (e_sc) begin
                mq.push_back({IDW'(N), sc_dat});
                m_acc++;
                if (sc_stream) sc_dat = rnd();
                else sc_val = 1'b0;
            end else if (g >= 0 && e_ir[g]) begin
                mq.push_back({IDW'(g), g_dat[g]});
                m_rr = (g + 1) % N;
                m_acc++;
                if (g_stream[g]) g_dat[g] = rnd();
                else g_val[g] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    task automatic rand_src();
        for (int i = 0; i < N; i++)
            if (!g_val[i] && $urandom_range(0, 2) == 0) begin
                g_val[i] = 1'b1;
                g_dat[i] = rnd();
            end
        if (!sc_val && $urandom_range(0, 4) == 0) begin
            sc_val = 1'b1;
            sc_dat = rnd();
        end
        out_ready = ($urandom_range(0, 9) < 7);
        reset     = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        int acc0;
        int pops0;
        int exp2[4];
        int exp3[9];
        exp2 = '{2, 5, 2, 5};
        exp3 = '{0, 1, 2, 8, 8, 8, 8, 8, 3};
        known = 1'b0;
        m_rr = 0; m_pops = 0; m_acc = 0; m_pw = '0; m_ps = '0;
        reset = 1'b1;
        out_ready = 1'b0;
        clear_src();
        drive();
        @(negedge clk);

        // reset with every input valid
        for (int i = 0; i < N; i++) begin g_val[i] = 1'b1; g_dat[i] = rnd(); end
        sc_val = 1'b1; sc_dat = rnd();
        do_reset(3);
        drive(); #1;
        chk("t1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_out_data", out_data, 64'd0);
        chk("t1_flying", 64'(has_flying_messages), 64'd1);

        // ports 2 and 5 alternate
        clear_src();
        do_reset(1);
        g_val[2] = 1'b1; g_stream[2] = 1'b1; g_dat[2] = rnd();
        g_val[5] = 1'b1; g_stream[5] = 1'b1; g_dat[5] = rnd();
        out_ready = 1'b1;
        pop_tags.delete();
        cycle();
        chk("t2_rr", 64'(m_rr), 64'd3);
        repeat (6) cycle();
        for (int i = 0; i < 4; i++) chk("t2_tag", 64'(pop_tags[i]), 64'(exp2[i]));

        // sc priority, then grid resumes at saved pointer
        clear_src();
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            g_val[i] = 1'b1; g_stream[i] = 1'b1; g_dat[i] = rnd();
        end
        out_ready = 1'b1;
        pop_tags.delete();
        repeat (3) cycle();
        sc_val = 1'b1; sc_stream = 1'b1; sc_dat = rnd();
        repeat (4) cycle();
        sc_stream = 1'b0;
        cycle();
        drive(); #1;
        chk("t3_resume", 64'(in_ready_vector), 64'h08);
        repeat (3) cycle();
        for (int i = 0; i < 9; i++) chk("t3_tag", 64'(pop_tags[i]), 64'(exp3[i]));

        // backpressure: exactly two words buffered
        clear_src();
        do_reset(1);
        g_val[0] = 1'b1; g_stream[0] = 1'b1; g_dat[0] = rnd();
        out_ready = 1'b0;
        acc0 = m_acc;
        repeat (5) cycle();
        chk("t4_acc", 64'(m_acc - acc0), 64'd2);
        drive(); #1;
        chk("t4_ready_low", 64'(in_ready_vector), 64'd0);
        g_stream[0] = 1'b0;
        out_ready = 1'b1;
        pops0 = m_pops;
        repeat (5) cycle();
        chk("t4_pops", 64'(m_pops - pops0), 64'd3);

        // reset with a full buffer
        clear_src();
        do_reset(1);
        g_val[0] = 1'b1; g_stream[0] = 1'b1; g_dat[0] = rnd();
        out_ready = 1'b0;
        repeat (3) cycle();
        clear_src();
        out_ready = 1'b1;
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            drive(); #1;
            chk("t5_out_valid", 64'(out_valid), 64'd0);
            cycle();
        end
        g_val[3] = 1'b1; g_dat[3] = rnd();
        g_val[1] = 1'b1; g_dat[1] = rnd();
        drive(); #1;
        chk("t5_rr0", 64'(in_ready_vector), 64'h02);
        repeat (4) cycle();

`ifdef HUB_ARB_PERF_COUNTERS_EN
        clear_src();
        do_reset(1);
        g_val[0] = 1'b1; g_stream[0] = 1'b1; g_dat[0] = rnd();
        out_ready = 1'b0;
        repeat (5) cycle();
        out_ready = 1'b1;
        repeat (8) cycle();
        g_stream[0] = 1'b0;
        repeat (6) cycle();
        drive(); #1;
        chk("t6_words", 64'(perf_words_out), 64'd10);
        chk("t6_stalls", 64'(perf_stall_cycles), 64'd4);
`endif

        // randomized traffic with occasional resets
        clear_src();
        do_reset(1);
        repeat (3000) begin
            rand_src();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
